simple_circuit_exerciser: RTL and testbench
===========================================

# simple_circuit_exerciser

Self-checking stimulus/response stage wrapped around the three-input `simple_circuit1` combinational block (Z = A2 | (B2 & C2)). It sits directly upstream and downstream of that block. On `start` it drives all eight {A2,B2,C2} combinations into the circuit, waits a settle time, and samples Z back. It compares each sample against the expected value and reports pass/fail, a mismatch count and a per-vector failure map for the lab board's LEDs.

## Interface
- `HOLD_CYCLES`, default 1: cycles each vector is driven before sampling; legal range 1..255.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin a run; honoured only in IDLE or DONE.
- `A2`  output  1  stimulus to circuit, vec[2]; registered.
- `B2`  output  1  stimulus to circuit, vec[1]; registered.
- `C2`  output  1  stimulus to circuit, vec[0]; registered.
- `Z`  input  1  circuit response, combinational from A2/B2/C2.
- `busy`  output  1  high in APPLY and SAMPLE.
- `done`  output  1  high in DONE.
- `pass`  output  1  valid when done; 1 iff err_count == 0.
- `err_count`  output  4  number of mismatching vectors, 0..8.
- `fail_map`  output  8  bit i set if vector i mismatched.
- `first_fail`  output  3  lowest-numbered failing vector; 0 if none.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE. State is binary encoded.
- Vector index `vec` is 3 bits, with {A2,B2,C2} = vec. The expected value is exp = vec[2] | (vec[1] & vec[0]).
- IDLE: outputs are at their reset values.
  - start=1: go to APPLY. vec=0, hold counter=0. Clear err_count, fail_map, first_fail and pass.
- APPLY: drive vec and increment the hold counter.
  - After HOLD_CYCLES cycles in APPLY, go to SAMPLE.
- SAMPLE: vec is still driven. At the end-of-cycle edge, Z is compared with exp.
  - On mismatch: set fail_map[vec] and increment err_count.
  - On the first mismatch of the run: first_fail <= vec.
  - If vec==7, go to DONE. Otherwise vec <= vec+1, clear the hold counter, and go to APPLY.
- DONE: done=1 and pass=(err_count==0). Results hold.
  - A2/B2/C2 return to 0.
  - start=1 starts a new run exactly as from IDLE, clearing all results.
- start while busy is ignored; it has no effect on vec or the results.
- err_count cannot exceed 8. A 4-bit width is required, with no saturation logic.
- Reset (any time, including mid-run): state=IDLE immediately.
  - A2=B2=C2=0, busy=0, done=0, pass=0, err_count=0, fail_map=0, first_fail=0.
  - Partial results are discarded.

## Timing
- All outputs are registered. There is no combinational path from Z or start to any output.
- Let edge 0 be the edge that samples start=1. busy is high from edge 0 onward, and A2/B2/C2 = vector 0 from edge 0 onward.
- Vector k is driven for HOLD_CYCLES+1 cycles: HOLD_CYCLES in APPLY plus 1 in SAMPLE.
- Z for vector k is sampled at edge (k+1)*(HOLD_CYCLES+1).
- done rises, and busy falls, at edge 8*(HOLD_CYCLES+1). For HOLD_CYCLES=1 this is edge 16.
- The Z sample requires Z to settle within HOLD_CYCLES cycles plus the combinational delay.
- err_count and fail_map update at the same edge as the corresponding sample.
- Restart from DONE: results clear at the start edge. The first vector is driven from that edge.

## Test plan
- HOLD_CYCLES=1, Z driven by a correct circuit model, pulse start:
  - done rises at edge 16, with pass=1, err_count=0, fail_map=8'h00, first_fail=0.
  - A2/B2/C2 step through 0..7, each held 2 cycles.
- Z tied 0:
  - err_count=5, fail_map=8'b1111_1000, first_fail=3, pass=0.
- Z tied 1:
  - err_count=3, fail_map=8'b0000_0111, first_fail=0, pass=0.
- Assert rst asynchronously while vec=4 in APPLY:
  - All outputs are 0 before the next edge.
  - A following start runs the full 16-cycle sequence with fresh results.
- Pulse start again at edge 5 of a run: the sequence and done time are unchanged.
  - After DONE with Z tied 0, restart with a correct Z: err_count and fail_map clear at the start edge, and the run ends pass=1.
- HOLD_CYCLES=3, correct Z: each vector is held 4 cycles; done rises at edge 32, pass=1.

Source files
------------

// File: rtl/simple_circuit_exerciser.sv
// simple_circuit_exerciser
// Drives all eight {A2,B2,C2} combinations into the simple_circuit1 block
// (Z = A2 | (B2 & C2)). Each vector is held for HOLD_CYCLES cycles and then
// Z is sampled for one more cycle. The block collects a mismatch count, a
// per-vector failure map and the lowest failing vector for the board LEDs.
// Every output comes straight from a flop, so Z and start never reach an
// output combinationally.

module simple_circuit_exerciser #(
  parameter int unsigned HOLD_CYCLES = 1  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A2,
  output logic       B2,
  output logic       C2,
  input  logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Value of the hold counter on the last APPLY cycle of a vector.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;          // index of the vector under test
  logic [7:0] hold_q, hold_d;        // cycles spent in APPLY for this vector
  logic [2:0] stim_q, stim_d;        // registered {A2,B2,C2}
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_count_q, err_count_d;
  logic [7:0] fail_map_q, fail_map_d;
  logic [2:0] first_fail_q, first_fail_d;

  // Golden response for the vector currently driven, and the compare result.
  logic exp_bit;
  logic mismatch;

  assign exp_bit  = vec_q[2] | (vec_q[1] & vec_q[0]);
  assign mismatch = Z ^ exp_bit;

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_map_d   = fail_map_q;
    first_fail_d = first_fail_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new run always starts from a clean slate, including from DONE.
        if (start) begin
          state_d      = ST_APPLY;
          vec_d        = 3'd0;
          hold_d       = 8'd0;
          stim_d       = 3'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = 4'd0;
          fail_map_d   = 8'd0;
          first_fail_d = 3'd0;
        end
      end

      ST_APPLY: begin
        // Give the circuit HOLD_CYCLES cycles to settle on the new vector.
        hold_d = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        // Vector is still driven; Z is captured at the end of this cycle.
        if (mismatch) begin
          fail_map_d[vec_q] = 1'b1;
          err_count_d       = err_count_q + 4'd1;  // at most 8, cannot wrap
          if (err_count_q == 4'd0) begin
            first_fail_d = vec_q;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = ST_DONE;
          stim_d  = 3'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 4'd0);
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec_q + 3'd1;
          stim_d  = vec_q + 3'd1;
          hold_d  = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= 3'd0;
      hold_q       <= 8'd0;
      stim_q       <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 4'd0;
      fail_map_q   <= 8'd0;
      first_fail_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_map_q   <= fail_map_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign A2         = stim_q[2];
  assign B2         = stim_q[1];
  assign C2         = stim_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_map   = fail_map_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_simple_circuit_exerciser.sv
// Testbench for simple_circuit_exerciser.
// Two instances (HOLD_CYCLES=1 and 3) share one clock and reset. The circuit
// under test is modelled as an 8-entry response table indexed by the DUT's
// stimulus, so correct, stuck-at and random faulty circuits are all easy to
// express. Expected values come from the golden Z = A2 | (B2 & C2) rule.

module tb_simple_circuit_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start3;
  logic [7:0] resp_tab;   // Z returned for each vector index
  bit         sel;        // 0: observe HOLD=1 instance, 1: HOLD=3 instance

  logic       a1, b1, c1, z1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] map1;
  logic [2:0] ff1;
  logic       a3, b3, c3, z3, busy3, done3, pass3;
  logic [3:0] err3;
  logic [7:0] map3;
  logic [2:0] ff3;

  assign z1 = resp_tab[{a1, b1, c1}];
  assign z3 = resp_tab[{a3, b3, c3}];

  simple_circuit_exerciser #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .A2(a1), .B2(b1), .C2(c1), .Z(z1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_map(map1), .first_fail(ff1)
  );

  simple_circuit_exerciser #(.HOLD_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .A2(a3), .B2(b3), .C2(c3), .Z(z3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_map(map3), .first_fail(ff3)
  );

  // Observed outputs of the instance selected for checking.
  logic [2:0] o_stim, o_ff;
  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [7:0] o_map;
  assign o_stim = sel ? {a3, b3, c3} : {a1, b1, c1};
  assign o_busy = sel ? busy3 : busy1;
  assign o_done = sel ? done3 : done1;
  assign o_pass = sel ? pass3 : pass1;
  assign o_err  = sel ? err3  : err1;
  assign o_map  = sel ? map3  : map1;
  assign o_ff   = sel ? ff3   : ff1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truth table of the correct circuit, bit v = expected Z for vector v.
  function automatic logic [7:0] golden_table();
    logic [7:0] t;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      t[i] = v[2] | (v[1] & v[0]);
    end
    return t;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, " rst stim"},  32'(o_stim), 32'd0);
    check({name, " rst busy"},  32'(o_busy), 32'd0);
    check({name, " rst done"},  32'(o_done), 32'd0);
    check({name, " rst pass"},  32'(o_pass), 32'd0);
    check({name, " rst err"},   32'(o_err),  32'd0);
    check({name, " rst map"},   32'(o_map),  32'd0);
    check({name, " rst first"}, 32'(o_ff),   32'd0);
  endtask

  // One run: start at edge 0, optional extra start pulse while busy, optional
  // asynchronous reset mid-cycle after edge abort_at. Every edge is checked.
  task automatic run_vectors(input string name, input logic [7:0] resp, input bit use3,
                             input int pulse_at, input int abort_at);
    int         p, t, s, errs;
    logic [7:0] miss, mask, fmap;
    logic [8:0] m9;
    logic [2:0] first, exp_stim;
    bit         in_run, st;
    string      tg;
    p        = (use3 ? 3 : 1) + 1;
    t        = 8 * p;
    sel      = use3;
    resp_tab = resp;
    miss     = resp ^ golden_table();
    for (int n = 0; n <= t + 1; n++) begin
      @(negedge clk);
      st     = (n == 0) || (n == pulse_at);
      start1 = st & !use3;
      start3 = st & use3;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start3 = 1'b0;
      in_run = (n < t);
      s      = in_run ? n / p : 8;       // vectors already sampled
      m9     = (9'd1 << s) - 9'd1;
      mask   = m9[7:0];
      fmap   = miss & mask;
      errs   = $countones(fmap);
      first  = 3'd0;
      for (int k = 7; k >= 0; k--) if (fmap[k]) first = 3'(k);
      exp_stim = in_run ? 3'(n / p) : 3'd0;
      tg = $sformatf("%s e%0d", name, n);
      check({tg, " stim"},  32'(o_stim), 32'(exp_stim));
      check({tg, " busy"},  32'(o_busy), 32'(in_run));
      check({tg, " done"},  32'(o_done), 32'(!in_run));
      check({tg, " pass"},  32'(o_pass), 32'(!in_run && errs == 0));
      check({tg, " err"},   32'(o_err),  32'(errs));
      check({tg, " map"},   32'(o_map),  32'(fmap));
      check({tg, " first"}, 32'(o_ff),   32'(first));
      if (n == abort_at) begin
        #2 rst = 1'b1;
        #1 check_all_zero(tg);
        @(negedge clk);
        rst = 1'b0;
        $display("run %s resp=%02h aborted by reset after edge %0d", name, resp, n);
        return;
      end
    end
    $display("run %s hold=%0d resp=%02h err=%0d map=%02h first=%0d pass=%0d",
             name, p - 1, resp, o_err, o_map, o_ff, o_pass);
  endtask

  initial begin
    logic [7:0] r;
    int         pa;
    rst      = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    sel      = 1'b0;
    resp_tab = golden_table();
    #12;
    check_all_zero("init h1");
    sel = 1'b1;
    check_all_zero("init h3");
    @(negedge clk);
    rst = 1'b0;

    run_vectors("correct",   golden_table(), 1'b0, -1, -1);
    run_vectors("tie0",      8'h00,          1'b0, -1, -1);
    run_vectors("tie1",      8'hff,          1'b0, -1, -1);
    run_vectors("abort",     golden_table(), 1'b0, -1, 8);
    run_vectors("fresh",     golden_table(), 1'b0, -1, -1);
    run_vectors("tie0b",     8'h00,          1'b0, -1, -1);
    run_vectors("restart",   golden_table(), 1'b0, 5,  -1);
    for (int i = 0; i < 6; i++) begin
      r  = 8'($urandom);
      pa = int'($urandom_range(1, 15));
      run_vectors($sformatf("rand%0d", i), r, 1'b0, pa, -1);
    end

    run_vectors("h3correct", golden_table(), 1'b1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      r  = 8'($urandom);
      pa = int'($urandom_range(1, 31));
      run_vectors($sformatf("h3rand%0d", i), r, 1'b1, pa, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
